// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings for the M-stage data-memory controller.
//   SIZE_*  : m_size encodings (2'b11 is reserved and treated as a word)
//   BE_*    : base byte-lane enables before shifting by the address offset
//   state_e : access FSM states
package dmem_pkg;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
endpackage

// File: rtl/dmem_align.sv
// dmem_align: combinational byte-lane logic for data-memory accesses.
//   Request side (live M-stage fields):
//     req_size_i, req_lane_i, req_wdata_i -> be_o, wdata_o, misaligned_o
//   Load side (fields registered at issue):
//     ld_size_i, ld_lane_i, ld_unsigned_i, ld_rdata_i -> ld_rdata_o (lane-selected, extended)
module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]  req_size_i,
    input  logic [1:0]  req_lane_i,
    input  logic [31:0] req_wdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o,
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_lane_i,
    input  logic        ld_unsigned_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_rdata_o
);
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    always_comb begin
        be_o         = BE_WORD;
        wdata_o      = req_wdata_i;
        misaligned_o = |req_lane_i;
        if (req_size_i == SIZE_BYTE) begin
            be_o         = BE_BYTE << req_lane_i;
            wdata_o      = {4{req_wdata_i[7:0]}};
            misaligned_o = 1'b0;
        end else if (req_size_i == SIZE_HALF) begin
            be_o         = req_lane_i[1] ? BE_HALF_HI : BE_HALF_LO;
            wdata_o      = {2{req_wdata_i[15:0]}};
            misaligned_o = req_lane_i[0];
        end
    end

    assign ld_b = ld_rdata_i[{ld_lane_i, 3'b000} +: 8];
    assign ld_h = ld_lane_i[1] ? ld_rdata_i[31:16] : ld_rdata_i[15:0];

    always_comb begin
        ld_rdata_o = ld_rdata_i;
        if (ld_size_i == SIZE_BYTE)
            ld_rdata_o = {{24{~ld_unsigned_i & ld_b[7]}}, ld_b};
        else if (ld_size_i == SIZE_HALF)
            ld_rdata_o = {{16{~ld_unsigned_i & ld_h[15]}}, ld_h};
    end
endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: M-stage load/store to data-memory req/ack controller.
//   clock, reset                 : rising-edge clock, async active-high reset
//   m_valid/m_read/m_write       : M-stage instruction and its memory op (store wins)
//   m_size/m_unsigned            : access size and load extension mode
//   m_addr/m_wdata               : byte address and store data
//   m_stall                      : global M stall; holds DONE until the instruction advances
//   m_dmem_stall                 : access outstanding (issue cycle and every BUSY cycle)
//   m_rdata                      : extended load data, captured on mem_ack
//   m_misaligned                 : misaligned half/word access, never issued
//   mem_req/we/addr/wdata/be     : registered request to data memory
//   mem_ack/mem_rdata            : one-cycle completion with raw read word
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m_valid,
    input  logic              m_read,
    input  logic              m_write,
    input  logic [1:0]        m_size,
    input  logic              m_unsigned,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    input  logic              m_stall,
    output logic              m_dmem_stall,
    output logic [DATA_W-1:0] m_rdata,
    output logic              m_misaligned,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);
    state_e            state_q, state_d;
    logic              issue, capture, mis, access, mem_op;
    logic [3:0]        be, be_q;
    logic [DATA_W-1:0] wdata_rep, ld_ext, wdata_q, rdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q, uns_q;
    logic [1:0]        size_q, lane_q;

    dmem_align u_align (
        .req_size_i    (m_size),
        .req_lane_i    (m_addr[1:0]),
        .req_wdata_i   (m_wdata),
        .be_o          (be),
        .wdata_o       (wdata_rep),
        .misaligned_o  (mis),
        .ld_size_i     (size_q),
        .ld_lane_i     (lane_q),
        .ld_unsigned_i (uns_q),
        .ld_rdata_i    (mem_rdata),
        .ld_rdata_o    (ld_ext)
    );

    assign mem_op       = m_valid & (m_read | m_write);
    assign m_misaligned = mem_op & mis;
    assign access       = mem_op & ~mis;

    // DONE is left only when the pipeline advances, so a held instruction is never re-issued.
    always_comb begin
        state_d      = state_q;
        issue        = 1'b0;
        capture      = 1'b0;
        m_dmem_stall = 1'b0;
        case (state_q)
            IDLE: if (access) begin
                state_d      = BUSY;
                issue        = 1'b1;
                m_dmem_stall = 1'b1;
            end
            BUSY: begin
                m_dmem_stall = 1'b1;
                if (mem_ack) begin
                    state_d = DONE;
                    capture = 1'b1;
                end
            end
            DONE: if (!m_stall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            size_q  <= '0;
            lane_q  <= '0;
            uns_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                we_q    <= m_write;
                addr_q  <= {m_addr[ADDR_W-1:2], 2'b00};
                wdata_q <= wdata_rep;
                be_q    <= be;
                size_q  <= m_size;
                lane_q  <= m_addr[1:0];
                uns_q   <= m_unsigned;
            end
            if (capture && !we_q) rdata_q <= ld_ext;
        end
    end

    // The request is the registered BUSY state, so async reset drops it immediately.
    assign mem_req   = state_q == BUSY;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;
    assign m_rdata   = rdata_q;
endmodule
